// File: rtl/bin2bcd_iter_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter.
// Holds the controller state encoding and a constant helper that tells
// how many decimal digits are needed to hold the largest BIN_W-bit value.
package bin2bcd_iter_pkg;

  // Controller states: waiting, shifting one bit per clock, result ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of decimal digits of 2^bin_w - 1 (the largest unsigned operand).
  // Signed mode never exceeds this, since its largest magnitude is 2^(bin_w-1).
  function automatic int min_digits(input int bin_w);
    longint unsigned value;
    int count;
    value = (64'd1 << bin_w) - 64'd1;
    count = 1;
    while (value >= 64'd10) begin
      value = value / 64'd10;
      count = count + 1;
    end
    return count;
  endfunction

endpackage

// File: rtl/bin2bcd_iter_digit_adj.sv
// Single BCD digit correction step of the double-dabble algorithm.
// A digit of 5 or more is bumped by 3 so that the following left shift
// carries correctly into the next decimal digit.
// Ports:
//   digit_in  - 4-bit BCD digit before correction
//   digit_out - corrected digit (digit_in + 3 when digit_in >= 5)
module bcd_digit_adj
  import bin2bcd_iter_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative (one bit per clock) binary to packed-BCD converter using the
// shift-and-add-3 method, with optional two's-complement input.
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset, overrides everything
//   start     - conversion request, only honoured when not busy
//   bin       - binary operand, captured together with start
//   is_signed - 1 treats bin as two's complement, captured with start
//   busy      - high while bits are being shifted
//   done      - one-cycle pulse when bcd/neg carry a fresh result
//   bcd       - packed BCD magnitude, digit 0 in bits [3:0]
//   neg       - result sign, 1 = negative (never set for zero)
module bin2bcd_iter
  import bin2bcd_iter_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Refuse to build configurations that cannot hold the result
  if (BIN_W < 2 || BIN_W > 32) begin : g_bad_width
    $error("bin2bcd_iter: BIN_W must be in 2..32");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_iter: DIGITS too small for BIN_W");
  end

  state_t            state;
  state_t            state_next;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_next;
  logic [BIN_W-1:0]  opr;
  logic [BIN_W-1:0]  opr_next;
  logic [BIN_W-1:0]  magnitude;
  logic [CNT_W-1:0]  cnt;
  logic              sign;
  logic              load;
  logic              last_shift;

  // A new request is accepted from IDLE or straight out of DONE
  assign load       = (state != SHIFT) && start;
  assign last_shift = (state == SHIFT) && (cnt == LAST_CNT);

  // Operand magnitude; the most negative value negates onto itself, which
  // read as unsigned is exactly the required 2^(BIN_W-1)
  always_comb begin
    magnitude = bin;
    if (is_signed && bin[BIN_W-1]) begin
      magnitude = ~bin + BIN_W'(1);
    end
  end

  // One correction cell per accumulator digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  // Corrected accumulator and operand move left together, operand MSB first
  assign {acc_next, opr_next} = {acc_adj, opr} << 1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift while busy, publish on the last shift.
  // bcd/neg only change on that last shift so intermediate sums never leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      opr  <= '0;
      cnt  <= '0;
      sign <= 1'b0;
      bcd  <= '0;
      neg  <= 1'b0;
    end else if (load) begin
      acc  <= '0;
      opr  <= magnitude;
      cnt  <= '0;
      sign <= is_signed & bin[BIN_W-1];
    end else if (state == SHIFT) begin
      acc <= acc_next;
      opr <= opr_next;
      cnt <= cnt + CNT_W'(1);
      if (last_shift) begin
        bcd <= acc_next;
        neg <= sign & (acc_next != '0);
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Scoreboard bench for bin2bcd_iter: an 8-bit/3-digit and a 16-bit/5-digit
// instance share clock and reset. Stimulus pushes expected results into
// per-instance queues; monitors pop and compare on every done pulse.
module tb_bin2bcd_iter;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8, sgn8, busy8, done8, neg8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;

  logic        start16, sgn16, busy16, done16, neg16;
  logic [15:0] bin16;
  logic [19:0] bcd16;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  typedef struct {
    logic [15:0] v;
    bit          s;
    logic [19:0] b;
    bit          n;
  } vec_t;

  exp_t        q8[$];
  exp_t        q16[$];
  int          errors = 0;
  int          checks = 0;
  logic [19:0] last8 = '0;
  logic [19:0] last16 = '0;

  always #5 clk = ~clk;

  bin2bcd_iter #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8), .is_signed(sgn8),
    .busy(busy8), .done(done8), .bcd(bcd8), .neg(neg8)
  );

  bin2bcd_iter #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16), .is_signed(sgn16),
    .busy(busy16), .done(done16), .bcd(bcd16), .neg(neg16)
  );

  // Compare one value and account for it
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference decimal digits by repeated division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int unsigned ref_mag(input int unsigned v, input bit s, input int w);
    if (s && v[w-1]) return (32'd1 << w) - v;
    return v;
  endfunction

  // Monitor for the 8-bit instance
  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && done8) begin
      checkOutput("dut8 done with result pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        checkOutput("dut8 bcd", 32'(bcd8), 32'(e.bcd[11:0]));
        checkOutput("dut8 neg", 32'(neg8), 32'(e.neg));
      end
    end
  end

  // Monitor for the 16-bit instance
  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst && done16) begin
      checkOutput("dut16 done with result pending", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        checkOutput("dut16 bcd", 32'(bcd16), 32'(e.bcd));
        checkOutput("dut16 neg", 32'(neg16), 32'(e.neg));
      end
    end
  end

  // Issue one conversion, queue its expected result and wait for done,
  // checking latency, busy length and that the old result is held meanwhile
  task automatic applyStimulus(input bit wide, input logic [15:0] value, input bit s,
                               input logic [19:0] exp_bcd, input bit exp_neg);
    exp_t e;
    int   lat;
    int   busy_n;
    int   w;
    e.bcd = exp_bcd;
    e.neg = exp_neg;
    w = wide ? 16 : 8;
    if (wide) begin
      q16.push_back(e);
      start16 = 1'b1; bin16 = value; sgn16 = s;
    end else begin
      q8.push_back(e);
      start8 = 1'b1; bin8 = value[7:0]; sgn8 = s;
    end
    tick;
    start8  = 1'b0;
    start16 = 1'b0;
    checkOutput("result held while busy", wide ? 32'(bcd16) : 32'(bcd8),
                wide ? 32'(last16) : 32'(last8));
    lat = 0;
    busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      if (wide ? busy16 : busy8) busy_n++;
      tick;
      if (wide ? done16 : done8) begin
        lat = n;
        break;
      end
    end
    checkOutput("done latency", 32'(lat), 32'(w));
    checkOutput("busy cycles", 32'(busy_n), 32'(w));
    if (lat == 0) begin
      if (wide && q16.size() != 0) void'(q16.pop_back());
      if (!wide && q8.size() != 0) void'(q8.pop_back());
    end
    if (wide) last16 = exp_bcd;
    else      last8  = exp_bcd;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    vec_t dir8[8];
    vec_t dir16[6];
    int   lat;
    int   busy_n;
    int   first_done;
    int   second_done;
    int   pulses;

    dir8 = '{
      '{16'h00FF, 1'b0, 20'h00255, 1'b0},
      '{16'h0080, 1'b1, 20'h00128, 1'b1},
      '{16'h0000, 1'b1, 20'h00000, 1'b0},
      '{16'h00FF, 1'b1, 20'h00001, 1'b1},
      '{16'h007F, 1'b1, 20'h00127, 1'b0},
      '{16'h009C, 1'b1, 20'h00100, 1'b1},
      '{16'h0080, 1'b0, 20'h00128, 1'b0},
      '{16'h000A, 1'b0, 20'h00010, 1'b0}
    };
    dir16 = '{
      '{16'hFFFF, 1'b0, 20'h65535, 1'b0},
      '{16'hFFFF, 1'b1, 20'h00001, 1'b1},
      '{16'h8000, 1'b1, 20'h32768, 1'b1},
      '{16'h3039, 1'b0, 20'h12345, 1'b0},
      '{16'h0000, 1'b1, 20'h00000, 1'b0},
      '{16'hD8F1, 1'b1, 20'h09999, 1'b1}
    };

    rst = 1'b1;
    start8 = 1'b0; bin8 = '0; sgn8 = 1'b0;
    start16 = 1'b0; bin16 = '0; sgn16 = 1'b0;
    repeat (3) tick;
    checkOutput("reset busy8", 32'(busy8), 32'd0);
    checkOutput("reset done8", 32'(done8), 32'd0);
    checkOutput("reset bcd8", 32'(bcd8), 32'd0);
    checkOutput("reset neg8", 32'(neg8), 32'd0);
    checkOutput("reset busy16", 32'(busy16), 32'd0);
    checkOutput("reset done16", 32'(done16), 32'd0);
    checkOutput("reset bcd16", 32'(bcd16), 32'd0);
    checkOutput("reset neg16", 32'(neg16), 32'd0);
    rst = 1'b0;
    tick;

    // Directed vectors, both widths
    foreach (dir8[i]) applyStimulus(1'b0, dir8[i].v, dir8[i].s, dir8[i].b, dir8[i].n);
    foreach (dir16[i]) applyStimulus(1'b1, dir16[i].v, dir16[i].s, dir16[i].b, dir16[i].n);

    // A second request three cycles into a conversion must be dropped
    begin
      exp_t e;
      e.bcd = 20'h00042; e.neg = 1'b0;
      q8.push_back(e);
    end
    start8 = 1'b1; bin8 = 8'h2A; sgn8 = 1'b0;
    tick;
    lat = 0;
    busy_n = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        start8 = 1'b1;
        bin8 = 8'h63;
      end else begin
        start8 = 1'b0;
      end
      if (busy8) busy_n++;
      tick;
      if (done8) begin
        lat = n;
        break;
      end
    end
    start8 = 1'b0;
    checkOutput("ignored start latency", 32'(lat), 32'd8);
    checkOutput("ignored start busy cycles", 32'(busy_n), 32'd8);
    last8 = 20'h00042;
    repeat (12) tick;

    // start held through DONE: two results, done pulses at edges 8 and 17
    begin
      exp_t e;
      e.bcd = 20'h00009; e.neg = 1'b0; q8.push_back(e);
      e.bcd = 20'h00100; e.neg = 1'b0; q8.push_back(e);
    end
    start8 = 1'b1; bin8 = 8'h09; sgn8 = 1'b0;
    tick;
    bin8 = 8'h64;
    first_done = 0;
    second_done = 0;
    pulses = 0;
    for (int n = 1; n <= 25; n++) begin
      tick;
      if (n == 9) start8 = 1'b0;
      if (done8) begin
        pulses++;
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
      end
    end
    checkOutput("back-to-back first done edge", 32'(first_done), 32'd8);
    checkOutput("back-to-back second done edge", 32'(second_done), 32'd17);
    checkOutput("back-to-back pulse count", 32'(pulses), 32'd2);
    last8 = 20'h00100;

    // Reset on the fourth edge of a conversion discards it
    start8 = 1'b1; bin8 = 8'h77; sgn8 = 1'b0;
    tick;
    start8 = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    checkOutput("mid reset busy8", 32'(busy8), 32'd0);
    checkOutput("mid reset done8", 32'(done8), 32'd0);
    checkOutput("mid reset bcd8", 32'(bcd8), 32'd0);
    checkOutput("mid reset neg8", 32'(neg8), 32'd0);
    checkOutput("mid reset bcd16", 32'(bcd16), 32'd0);
    rst = 1'b0;
    last8 = '0;
    last16 = '0;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      tick;
      if (done8) pulses++;
    end
    checkOutput("done after reset", 32'(pulses), 32'd0);

    // Full 8-bit sweep in both modes against the division model
    for (int v = 0; v < 256; v++) begin
      for (int s = 0; s < 2; s++) begin
        applyStimulus(1'b0, 16'(v), s[0], ref_bcd(ref_mag(v, s[0], 8)),
                      s[0] && (v >= 128));
      end
    end

    // Strided unsigned 16-bit sweep plus the top value
    for (int v = 0; v < 65536; v += 773) begin
      applyStimulus(1'b1, 16'(v), 1'b0, ref_bcd(v), 1'b0);
    end
    applyStimulus(1'b1, 16'hFFFF, 1'b0, ref_bcd(65535), 1'b0);

    repeat (3) tick;
    checkOutput("dut8 queue drained", 32'(q8.size()), 32'd0);
    checkOutput("dut16 queue drained", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
